// File: rtl/tinker_fetch_unit.sv
// Tinker instruction fetch stage: owns the PC, issues credit-limited imem reads, buffers
// returned words in an in-order prefetch FIFO and squashes stale responses on redirect.
module tinker_fetch_unit #(
    parameter int unsigned          ADDR_W   = 64,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(64'h2000)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [31:0]       fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  drop_cnt;

    logic              credit_ok;
    logic              req_fire;
    logic              rsp_drop;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  inflight_nxt;
    logic [SUM_W-1:0]  occupancy;
    logic [ADDR_W-1:0] redirect_aligned;

    // Requests are only issued while a FIFO slot is guaranteed for the response.
    always_comb begin
        occupancy        = SUM_W'(count) + SUM_W'(inflight);
        credit_ok        = occupancy < SUM_W'(DEPTH);
        imem_req_valid   = !reset && !halt && !redirect_valid && credit_ok;
        imem_req_addr    = fetch_pc;
        req_fire         = imem_req_valid && imem_req_ready;
        rsp_drop         = imem_rsp_valid && (drop_cnt != '0);
        push             = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
        pop              = inst_valid && inst_ready && !redirect_valid;
        inflight_nxt     = inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        redirect_aligned = redirect_pc & ~ADDR_W'(3);
    end

    always_comb begin
        inst_valid  = (count != '0);
        instruction = inst_valid ? fifo_data[rd_ptr] : 32'h0;
        inst_pc     = inst_valid ? fifo_pc[rd_ptr]   : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_data[i] <= 32'h0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            // Everything still outstanding (including a response landing now) becomes stale.
            fetch_pc <= redirect_aligned;
            resp_pc  <= redirect_aligned;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight_nxt;
            drop_cnt <= inflight_nxt;
        end else begin
            inflight <= inflight_nxt;
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (push) begin
                fifo_data[wr_ptr] <= imem_rsp_data;
                fifo_pc[wr_ptr]   <= resp_pc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
                resp_pc           <= resp_pc + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Structural invariants of the credit scheme.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_credit: assert (occupancy <= SUM_W'(DEPTH));
            a_drop:   assert (drop_cnt <= inflight);
            a_rsp:    assert (!(imem_rsp_valid && (inflight == '0)));
        end
    end

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Randomized scoreboard bench for tinker_fetch_unit with an in-order memory model and an
// epoch-based reference of the instruction stream the decoder should see.
module tb_tinker_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [63:0] inst_pc;
    logic        inst_ready;

    tinker_fetch_unit #(.ADDR_W(64), .DEPTH(4), .RESET_PC(64'h2000)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt),
        .inst_valid(inst_valid), .instruction(instruction), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [63:0] pc; logic [31:0] data; } exp_t;

    mreq_t       mq[$];
    exp_t        sq[$];
    mreq_t       mh;
    exp_t        eh;
    int          cyc = 0;
    int          epoch = 0;
    int          inflight_m = 0;
    int          last_due = 0;
    int          mode = 0;
    int          halt_left = 0;
    logic [63:0] model_pc;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model and scoreboard, evaluated mid-cycle on the values the next edge will see.
    always @(negedge clk) begin
        if (!reset) begin
            logic exp_rv;
            logic fire;
            logic rsp;
            int   lat;
            int   d;
            exp_rv = !halt && !redirect_valid && ((sq.size() + inflight_m) < DEPTH);
            chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
            chk("inst_valid", 64'(inst_valid), 64'(sq.size() != 0));
            fire = imem_req_valid && imem_req_ready;
            rsp  = imem_rsp_valid;
            if (fire) begin
                chk("req_addr", imem_req_addr, model_pc);
                lat = (mode == 2) ? int'($urandom_range(1, 3)) : 1;
                d = cyc + lat;
                if (d < last_due) d = last_due;
                last_due = d;
                mq.push_back('{addr: model_pc, due: d, epoch: epoch});
                model_pc = model_pc + 64'd4;
                inflight_m++;
            end
            if (rsp) begin
                mh = mq.pop_front();
                inflight_m--;
            end
            if (inst_valid && inst_ready && !redirect_valid && sq.size() != 0) begin
                eh = sq.pop_front();
                chk("inst_pc", inst_pc, eh.pc);
                chk("instruction", 64'(instruction), 64'(eh.data));
            end
            if (rsp && mh.epoch == epoch && !redirect_valid)
                sq.push_back('{pc: mh.addr, data: word_at(mh.addr)});
            if (redirect_valid) begin
                sq.delete();
                epoch++;
                model_pc = redirect_pc & ~64'h3;
            end
        end
    end

    task automatic drive_cycle();
        @(posedge clk);
        cyc++;
        #1;
        redirect_valid = 1'b0;
        case (mode)
            0: begin imem_req_ready = 1'b1; inst_ready = 1'b1; halt = 1'b0; end
            1: begin imem_req_ready = 1'b1; inst_ready = 1'b0; halt = 1'b0; end
            2: begin
                imem_req_ready = ($urandom_range(0, 3) != 0);
                inst_ready     = ($urandom_range(0, 9) < 7);
                if (halt_left == 0 && $urandom_range(0, 99) < 3) halt_left = 5;
                halt = (halt_left != 0);
                if (halt_left != 0) halt_left--;
                if ($urandom_range(0, 99) < 6) begin
                    redirect_valid = 1'b1;
                    case ($urandom_range(0, 3))
                        0:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                        1:       redirect_pc = 64'h3002;
                        default: redirect_pc = {32'($urandom), 32'($urandom)};
                    endcase
                end
            end
            default: begin imem_req_ready = 1'b1; inst_ready = 1'b1; halt = 1'b1; end
        endcase
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mq.size() != 0 && mq[0].due <= cyc && (mode != 2 || $urandom_range(0, 4) != 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(mq[0].addr);
        end
    endtask

    initial begin
        reset = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0; halt = 1'b0; inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_valid", 64'(inst_valid), 64'h0);
        chk("rst_instruction", 64'(instruction), 64'h0);
        chk("rst_inst_pc", inst_pc, 64'h0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
        model_pc = 64'h2000;
        @(posedge clk);
        #1 reset = 1'b0;

        mode = 0; repeat (30) drive_cycle();
        mode = 1; repeat (10) drive_cycle();
        mode = 0; repeat (10) drive_cycle();
        // Directed wrap across the top of the address space.
        @(posedge clk); cyc++; #1;
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        imem_rsp_valid = (mq.size() != 0 && mq[0].due <= cyc);
        imem_rsp_data  = imem_rsp_valid ? word_at(mq[0].addr) : 32'h0;
        repeat (15) drive_cycle();
        mode = 2; repeat (3000) drive_cycle();
        mode = 3; repeat (40) drive_cycle();

        @(posedge clk); #2;
        chk("drain_sq_empty", 64'(sq.size()), 64'h0);
        chk("drain_mem_empty", 64'(mq.size()), 64'h0);
        chk("drain_inflight", 64'(inflight_m), 64'h0);
        chk("drain_inst_valid", 64'(inst_valid), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
